fft_sequencer: RTL and testbench
================================

Name: fft_sequencer

Overview:
- Frame-level controller for the radix-2 DIT FFT datapath. Loads N samples into the shared node memory in bit-reversed order, then issues log2(N)×N/2 butterfly operations to the single butterfly unit. Each issue carries its address pair, twiddle index and stage.
- After the last butterfly it streams results out in natural order and returns to loading. It holds no sample data; it generates addresses, strobes and handshakes only.

Parameters:
- N, 8: FFT points; a power of two, minimum 4.
- LOGN, 3: log2(N); must match N.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  input sample offered.
- in_ready  output  1  sequencer accepts a sample this cycle.
- mem_we  output  1  write strobe to node memory for the accepted sample.
- mem_waddr  output  LOGN  bit-reversed write address for the sample.
- bf_req  output  1  butterfly operation requested.
- bf_ack  input  1  butterfly unit has consumed the request.
- bf_addr_a  output  LOGN  upper node index.
- bf_addr_b  output  LOGN  lower node index (bf_addr_a + 2^stage).
- bf_tw_idx  output  LOGN-1  twiddle exponent k of W_N^k.
- bf_stage  output  LOGN  current stage, 0..LOGN-1.
- out_valid  output  1  result address valid.
- out_ready  input  1  downstream accepts the result.
- out_addr  output  LOGN  natural-order read address.
- out_last  output  1  marks address N-1.
- busy  output  1  high in COMPUTE or DRAIN.
- frame_done  output  1  one-cycle pulse after the last output handshake.

Behaviour:
- Reset: state LOAD; all counters 0; in_ready=1; mem_we=0; bf_req=0; out_valid=0; out_last=0; busy=0; frame_done=0. Assertion at any time aborts the current frame; no partial outputs follow.
- State machine: LOAD → COMPUTE → DRAIN → LOAD. Counters are registered. Handshake outputs are combinational from state and counters only, never from their own handshake input.
- LOAD:
  - in_ready=1.
  - On in_valid, same cycle: mem_we=1 and mem_waddr=bitrev(cnt), where bitrev reverses LOGN bits; then cnt++.
  - Accept at cnt=N-1: cnt←0, stage←0, bfly←0, go to COMPUTE.
  - in_valid low: no write, no count.
- COMPUTE:
  - bf_req=1 continuously; in_ready=0.
  - half=2^stage, pos=bfly mod half, group=bfly/half.
  - bf_addr_a = group·2·half + pos; bf_addr_b = bf_addr_a + half; bf_tw_idx = pos·2^(LOGN-1-stage); bf_stage = stage.
  - Outputs stay stable until bf_ack. On bf_ack, the operation completes and bfly++.
  - At bfly=N/2-1: bfly←0, stage++.
  - At stage=LOGN-1 with bfly=N/2-1: go to DRAIN.
  - Ack may arrive the same cycle req first rises (zero-wait), giving one op per cycle.
  - bf_ack outside COMPUTE is ignored.
- DRAIN:
  - out_valid=1; out_addr=cnt; out_last=(cnt==N-1).
  - On out_ready: cnt++.
  - On the last handshake: frame_done=1 for the next cycle, cnt←0, go to LOAD.
  - out_ready low: address held. in_valid ignored (in_ready=0).
- No overlap between frames. busy=1 exactly in COMPUTE and DRAIN.

Test Plan:
- N=8, in_valid held high with samples 0..7 → mem_waddr sequence 0,4,2,6,1,5,3,7 on consecutive cycles; in_ready drops the cycle after the 8th accept.
- bf_ack tied high → 12 consecutive ops:
  - stage0 pairs (0,1)(2,3)(4,5)(6,7), tw 0,0,0,0.
  - stage1 pairs (0,2)(1,3)(4,6)(5,7), tw 0,2,0,2.
  - stage2 pairs (0,4)(1,5)(2,6)(3,7), tw 0,1,2,3.
  - DRAIN follows next cycle.
- bf_ack delayed 3 cycles per op → addresses and tw held stable while unacked; total COMPUTE = 48 cycles; a stray bf_ack in LOAD has no effect.
- out_ready toggled 1,0,1,0… → out_addr 0..7, each held through stall cycles; out_last only with addr 7; frame_done pulses once; state back to LOAD with in_ready=1.
- rst asserted mid-COMPUTE (stage1, bfly2) → asynchronously bf_req=0, in_ready=1, busy=0. The next frame restarts with mem_waddr 0,4,….
- in_valid gapped (1,0,0,1,…) during LOAD → exactly 8 writes, no counting on idle cycles. Two back-to-back frames produce identical op sequences.

Source files
------------

// File: rtl/fft_sequencer.sv
// fft_sequencer
// Frame-level controller for a radix-2 DIT FFT datapath. It writes N incoming
// samples into node memory in bit-reversed order. It then issues LOGN*N/2
// butterfly operations to one butterfly unit. Last, it streams result
// addresses out in natural order. It carries no sample data.
//
// Ports:
//   clk, rst                  clock (rising edge) and async active-high reset
//   in_valid / in_ready       sample handshake during LOAD
//   mem_we / mem_waddr        node-memory write strobe and bit-reversed address
//   bf_req / bf_ack           butterfly request handshake during COMPUTE
//   bf_addr_a / bf_addr_b     upper / lower node index of the butterfly
//   bf_tw_idx / bf_stage      twiddle exponent k of W_N^k, and current stage
//   out_valid / out_ready     result-address handshake during DRAIN
//   out_addr / out_last       natural-order read address, high for address N-1
//   busy                      high in COMPUTE and DRAIN
//   frame_done                one-cycle pulse after the final output handshake
module fft_sequencer #(
  parameter int N    = 8,
  parameter int LOGN = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            mem_we,
  output logic [LOGN-1:0] mem_waddr,
  output logic            bf_req,
  input  logic            bf_ack,
  output logic [LOGN-1:0] bf_addr_a,
  output logic [LOGN-1:0] bf_addr_b,
  output logic [LOGN-2:0] bf_tw_idx,
  output logic [LOGN-1:0] bf_stage,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGN-1:0] out_addr,
  output logic            out_last,
  output logic            busy,
  output logic            frame_done
);

  localparam int BW = LOGN - 1;  // butterfly index width: 0..N/2-1

  localparam logic [LOGN-1:0] CNT_LAST   = LOGN'(N - 1);
  localparam logic [LOGN-1:0] STAGE_LAST = LOGN'(LOGN - 1);
  localparam logic [BW-1:0]   BFLY_LAST  = BW'(N / 2 - 1);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [LOGN-1:0] cnt_q, cnt_d;
  logic [LOGN-1:0] stage_q, stage_d;
  logic [BW-1:0]   bfly_q, bfly_d;
  logic            frame_done_q, frame_done_d;

  // Address generation terms
  logic [LOGN-1:0] half;      // 2^stage
  logic [LOGN-1:0] bfly_ext;
  logic [LOGN-1:0] pos;       // bfly mod half
  logic [LOGN-1:0] addr_a;
  logic [LOGN-1:0] tw_shift;
  logic [LOGN-1:0] tw_full;
  logic [LOGN-1:0] waddr_rev;

  // Handshake outputs depend only on state and counters. The one exception is
  // mem_we, which qualifies an accepted sample with in_valid.
  // NOTE: every combinational output gets a value on every path. Without that,
  // an incomplete assignment would infer a latch.
  always_comb begin
    in_ready   = (state_q == ST_LOAD);
    mem_we     = (state_q == ST_LOAD) && in_valid;
    bf_req     = (state_q == ST_COMPUTE);
    out_valid  = (state_q == ST_DRAIN);
    out_addr   = cnt_q;
    out_last   = (state_q == ST_DRAIN) && (cnt_q == CNT_LAST);
    busy       = (state_q == ST_COMPUTE) || (state_q == ST_DRAIN);
    frame_done = frame_done_q;

    for (int i = 0; i < LOGN; i++) begin
      waddr_rev[i] = cnt_q[LOGN-1-i];
    end
    mem_waddr = waddr_rev;
  end

  // group*2*half is the bfly bits above the pos field, shifted up by one.
  // The lower node sets the half bit, which is always clear in addr_a.
  always_comb begin
    half      = LOGN'(1) << stage_q;
    bfly_ext  = {1'b0, bfly_q};
    pos       = bfly_ext & (half - LOGN'(1));
    addr_a    = ((bfly_ext & ~(half - LOGN'(1))) << 1) | pos;
    tw_shift  = STAGE_LAST - stage_q;
    tw_full   = pos << tw_shift;
    bf_addr_a = addr_a;
    bf_addr_b = addr_a + half;
    bf_tw_idx = tw_full[LOGN-2:0];
    bf_stage  = stage_q;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stage_d      = stage_q;
    bfly_d       = bfly_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            stage_d = '0;
            bfly_d  = '0;
            state_d = ST_COMPUTE;
          end else begin
            cnt_d = cnt_q + LOGN'(1);
          end
        end
      end
      ST_COMPUTE: begin
        // bf_ack is sampled here only; in any other state it has no effect.
        if (bf_ack) begin
          if (bfly_q == BFLY_LAST) begin
            bfly_d = '0;
            if (stage_q == STAGE_LAST) begin
              stage_d = '0;
              state_d = ST_DRAIN;
            end else begin
              stage_d = stage_q + LOGN'(1);
            end
          end else begin
            bfly_d = bfly_q + BW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d        = '0;
            frame_done_d = 1'b1;
            state_d      = ST_LOAD;
          end else begin
            cnt_d = cnt_q + LOGN'(1);
          end
        end
      end
      default: begin
        state_d = ST_LOAD;
        cnt_d   = '0;
        stage_d = '0;
        bfly_d  = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops then
  // update together at the edge, whatever order the statements appear in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      cnt_q        <= '0;
      stage_q      <= '0;
      bfly_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stage_q      <= stage_d;
      bfly_q       <= bfly_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_fft_sequencer.sv
module tb_fft_sequencer;

  localparam int N    = 8;
  localparam int LOGN = 3;
  localparam int OPS  = LOGN * N / 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            mem_we;
  logic [LOGN-1:0] mem_waddr;
  logic            bf_req;
  logic            bf_ack = 1'b0;
  logic [LOGN-1:0] bf_addr_a;
  logic [LOGN-1:0] bf_addr_b;
  logic [LOGN-2:0] bf_tw_idx;
  logic [LOGN-1:0] bf_stage;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [LOGN-1:0] out_addr;
  logic            out_last;
  logic            busy;
  logic            frame_done;

  int passed = 0;
  int total  = 0;

  // Reference butterfly schedule, built from the DIT stage/group/position rule
  int exp_a [OPS];
  int exp_b [OPS];
  int exp_tw[OPS];
  int exp_st[OPS];

  fft_sequencer #(.N(N), .LOGN(LOGN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr),
    .bf_req(bf_req), .bf_ack(bf_ack),
    .bf_addr_a(bf_addr_a), .bf_addr_b(bf_addr_b),
    .bf_tw_idx(bf_tw_idx), .bf_stage(bf_stage),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_last(out_last),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic int bitrev(input int v);
    int r = 0;
    for (int i = 0; i < LOGN; i++) r = r * 2 + ((v >> i) & 1);
    return r;
  endfunction

  task automatic build_model();
    int k = 0;
    for (int s = 0; s < LOGN; s++) begin
      int h = 1 << s;
      for (int g = 0; g < N; g += 2 * h) begin
        for (int p = 0; p < h; p++) begin
          exp_a[k]  = g + p;
          exp_b[k]  = g + p + h;
          exp_tw[k] = p * (N / (2 * h));
          exp_st[k] = s;
          k++;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; bf_ack = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    total++;
    if ({in_ready, mem_we, bf_req, out_valid, out_last, busy, frame_done} !== 7'b1000000)
      $display("FAIL reset_state: got %b want 1000000",
               {in_ready, mem_we, bf_req, out_valid, out_last, busy, frame_done});
    else passed++;
    rst = 1'b0;
  endtask

  // mode 0: in_valid held high, 1: pattern 1,0,0, 2: random gaps
  task automatic test_load(input int mode);
    int acc = 0;
    int cyc = 0;
    while (acc < N && cyc < 200) begin
      @(negedge clk);
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 3 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      bf_ack    = 1'($urandom_range(0, 1));   // stray acks must be ignored
      out_ready = 1'($urandom_range(0, 1));
      #1;
      total++;
      if ({in_ready, mem_we, bf_req, out_valid, busy} !== {1'b1, in_valid, 3'b000})
        $display("FAIL load_ctrl: cnt %0d got %b want %b", acc,
                 {in_ready, mem_we, bf_req, out_valid, busy}, {1'b1, in_valid, 3'b000});
      else passed++;
      if (in_valid) begin
        total++;
        if (mem_waddr !== LOGN'(bitrev(acc)))
          $display("FAIL load_waddr: sample %0d got %0d want %0d", acc, mem_waddr, bitrev(acc));
        else passed++;
        acc++;
      end
      cyc++;
    end
    if (acc < N) begin
      total++;
      $display("FAIL load_timeout: accepted %0d want %0d", acc, N);
    end
  endtask

  // ack_delay >= 0: ack on the (ack_delay+1)th cycle of each op; < 0: random
  task automatic test_compute(input int ack_delay);
    for (int i = 0; i < OPS; i++) begin
      int d = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
      for (int w = 0; w <= d; w++) begin
        @(negedge clk);
        bf_ack    = (w == d);
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        #1;
        total++;
        if ({in_ready, mem_we, bf_req, out_valid, busy, bf_addr_a, bf_addr_b, bf_tw_idx, bf_stage}
            !== {5'b00101, LOGN'(exp_a[i]), LOGN'(exp_b[i]), (LOGN-1)'(exp_tw[i]), LOGN'(exp_st[i])})
          $display("FAIL compute_op%0d: wait %0d got ctl=%b a=%0d b=%0d tw=%0d st=%0d want a=%0d b=%0d tw=%0d st=%0d",
                   i, w, {in_ready, mem_we, bf_req, out_valid, busy}, bf_addr_a, bf_addr_b,
                   bf_tw_idx, bf_stage, exp_a[i], exp_b[i], exp_tw[i], exp_st[i]);
        else passed++;
      end
    end
    // DRAIN must begin on the cycle right after the last ack
    @(negedge clk);
    bf_ack = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    #1;
    total++;
    if ({bf_req, out_valid, busy, out_addr} !== {3'b011, LOGN'(0)})
      $display("FAIL compute_to_drain: got %b want %b",
               {bf_req, out_valid, busy, out_addr}, {3'b011, LOGN'(0)});
    else passed++;
  endtask

  // mode 0: out_ready 1,0,1,0..., 1: random, 2: held high
  task automatic test_drain(input int mode);
    int k = 0;
    int cyc = 0;
    while (k < N && cyc < 200) begin
      @(negedge clk);
      case (mode)
        0:       out_ready = (cyc % 2 == 0);
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      in_valid = 1'($urandom_range(0, 1));
      bf_ack   = 1'($urandom_range(0, 1));
      #1;
      total++;
      if ({in_ready, mem_we, bf_req, out_valid, busy, out_last, frame_done, out_addr}
          !== {5'b00011, (k == N - 1), 1'b0, LOGN'(k)})
        $display("FAIL drain_addr: got ctl=%b addr=%0d want last=%0d addr=%0d",
                 {in_ready, mem_we, bf_req, out_valid, busy, out_last, frame_done},
                 out_addr, (k == N - 1), k);
      else passed++;
      if (out_ready) k++;
      cyc++;
    end
    if (k < N) begin
      total++;
      $display("FAIL drain_timeout: handshakes %0d want %0d", k, N);
    end
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0; bf_ack = 1'b0;
    #1;
    total++;
    if ({frame_done, in_ready, busy, out_valid} !== 4'b1100)
      $display("FAIL frame_done_pulse: got %b want 1100", {frame_done, in_ready, busy, out_valid});
    else passed++;
    @(negedge clk); #1;
    total++;
    if ({frame_done, in_ready} !== 2'b01)
      $display("FAIL frame_done_single: got %b want 01", {frame_done, in_ready});
    else passed++;
  endtask

  task automatic run_frame(input int load_mode, input int ack_delay, input int drain_mode);
    test_load(load_mode);
    test_compute(ack_delay);
    test_drain(drain_mode);
  endtask

  // Abort in stage 1, bfly 2 (schedule entry 6), then run a clean frame
  task automatic test_reset_mid();
    test_load(0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bf_ack = 1'b1; in_valid = 1'b0;
    end
    @(negedge clk);
    bf_ack = 1'b0;
    #1;
    total++;
    if ({bf_req, bf_stage, bf_addr_a, bf_addr_b} !== {1'b1, LOGN'(exp_st[6]), LOGN'(exp_a[6]), LOGN'(exp_b[6])})
      $display("FAIL pre_abort_op: got st=%0d a=%0d b=%0d want st=%0d a=%0d b=%0d",
               bf_stage, bf_addr_a, bf_addr_b, exp_st[6], exp_a[6], exp_b[6]);
    else passed++;
    #1 rst = 1'b1;
    #1;
    total++;
    if ({bf_req, in_ready, busy, out_valid} !== 4'b0100)
      $display("FAIL async_abort: got %b want 0100", {bf_req, in_ready, busy, out_valid});
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    run_frame(0, 0, 2);
  endtask

  task automatic test_back_to_back();
    run_frame(2, -1, 1);
    run_frame(2, -1, 1);
  endtask

  initial begin
    build_model();
    test_reset();
    run_frame(0, 0, 0);   // held-high load, zero-wait ack, toggled out_ready
    run_frame(1, 3, 1);   // gapped load, 3-cycle ack delay, random out_ready
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
